// File: rtl/kb_matrix_scanner.sv
// -----------------------------------------------------------------------------
// kb_matrix_scanner
//
// Scans a 4x4 matrix keypad one row at a time and debounces the result over
// whole scans. The output is the 5-bit keyboard index read by the MMIO block:
// bit [4] = key held, bits [3:0] = key code.
//
// Parameters:
//   SCAN_DIV  clock cycles each row is driven before its columns are sampled (>=4)
//   DEBOUNCE  consecutive full scans needed to commit a press or a release (>=1)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous reset, active-low
//   row_n     row drive, one-cold (driven row is 0)
//   col_n     column sense, active-low, asynchronous to clk
//   kb_idx    [4] = key held, [3:0] = key code
//   kb_press  one-cycle pulse as kb_idx[4] rises (only with KB_PRESS_PULSE_EN)
//
// Optional feature macro: KB_PRESS_PULSE_EN adds the kb_press output.
// -----------------------------------------------------------------------------
module kb_matrix_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [4:0] kb_idx
`ifdef KB_PRESS_PULSE_EN
    ,
    output logic       kb_press
`endif
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } state_t;

    logic [3:0]    col_s1_q, col_s2_q;
    logic [DW-1:0] div_q;
    logic [1:0]    row_q;
    logic [3:0]    row_n_q;
    logic          acc_hit_q;
    logic [3:0]    acc_code_q;
    state_t        state_q;
    logic [3:0]    cand_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    kb_idx_q;
`ifdef KB_PRESS_PULSE_EN
    logic          press_q;
`endif

    logic          sample;
    logic          scan_end;
    logic          row_hit;
    logic [3:0]    row_code;
    logic          scan_hit;
    logic [3:0]    scan_code;
    logic          match;

    // Lowest-numbered active column wins within a row.
    function automatic logic [1:0] first_low(input logic [3:0] low);
        logic [1:0] pos = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (low[i]) pos = 2'(i);
        end
        return pos;
    endfunction

    // Keypad legend: row0 1 2 3 A / row1 4 5 6 B / row2 7 8 9 C / row3 * 0 # D
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = 4'd10;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = 4'd11;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = 4'd12;
            4'hC:    code = 4'd14;
            4'hD:    code = 4'd0;
            4'hE:    code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    // Per-row result merged with what earlier rows of this scan found.
    // Row 0 starts a fresh scan, so the accumulator is ignored there.
    always_comb begin
        sample   = (div_q == DIV_LAST);
        scan_end = sample && (row_q == 2'd3);
        row_hit  = |(~col_s2_q);
        row_code = key_code(row_q, first_low(~col_s2_q));
        if ((row_q == 2'd0) || !acc_hit_q) begin
            scan_hit  = row_hit;
            scan_code = row_code;
        end else begin
            scan_hit  = 1'b1;
            scan_code = acc_code_q;
        end
        match = scan_hit && (scan_code == cand_q);
    end

    // Column synchroniser, row divider and per-scan accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q   <= 4'hF;
            col_s2_q   <= 4'hF;
            div_q      <= '0;
            row_q      <= 2'd0;
            row_n_q    <= 4'b1110;
            acc_hit_q  <= 1'b0;
            acc_code_q <= 4'd0;
        end else begin
            col_s1_q <= col_n;
            col_s2_q <= col_s1_q;
            if (sample) begin
                div_q      <= '0;
                row_q      <= row_q + 2'd1;
                row_n_q    <= {row_n_q[2:0], row_n_q[3]};
                acc_hit_q  <= scan_hit;
                acc_code_q <= scan_code;
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    // Debounce FSM, evaluated once per full scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cand_q   <= 4'd0;
            cnt_q    <= '0;
            kb_idx_q <= 5'b0_0000;
`ifdef KB_PRESS_PULSE_EN
            press_q  <= 1'b0;
`endif
        end else begin
`ifdef KB_PRESS_PULSE_EN
            press_q <= 1'b0;
`endif
            if (scan_end) begin
                case (state_q)
                    IDLE: begin
                        if (scan_hit) begin
                            cand_q <= scan_code;
                            if (DEBOUNCE == 1) begin
                                kb_idx_q <= {1'b1, scan_code};
                                cnt_q    <= '0;
                                state_q  <= HELD;
`ifdef KB_PRESS_PULSE_EN
                                press_q  <= 1'b1;
`endif
                            end else begin
                                cnt_q   <= CW'(1);
                                state_q <= PRESS;
                            end
                        end
                    end
                    PRESS: begin
                        if (match) begin
                            if (cnt_q == CNT_LAST) begin
                                kb_idx_q <= {1'b1, cand_q};
                                cnt_q    <= '0;
                                state_q  <= HELD;
`ifdef KB_PRESS_PULSE_EN
                                press_q  <= 1'b1;
`endif
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end else begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                    HELD: begin
                        // A different key counts as a release; it is picked up
                        // fresh once the FSM is back in IDLE.
                        if (match) begin
                            cnt_q <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            kb_idx_q[4] <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign row_n  = row_n_q;
    assign kb_idx = kb_idx_q;
`ifdef KB_PRESS_PULSE_EN
    assign kb_press = press_q;
`endif

endmodule

// File: tb/tb_kb_matrix_scanner.sv
`timescale 1ns/1ps
module tb_kb_matrix_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [4:0] kb_idx;
`ifdef KB_PRESS_PULSE_EN
    logic       kb_press;
`endif

    logic [15:0] pressed = 16'h0;   // bit r*4+c = key at (row r, col c) held down
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kb_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .row_n  (row_n),
        .col_n  (col_n),
        .kb_idx (kb_idx)
`ifdef KB_PRESS_PULSE_EN
        ,
        .kb_press (kb_press)
`endif
    );

    // Passive keypad: a column reads low when a pressed key links it to the driven row.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row_n[r] === 1'b0 && pressed[r*4+c]) col_n[c] = 1'b0;
    end

    // ---------------- scan-level reference model ----------------
    int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int         m_mode;    // 0 waiting, 1 confirming press, 2 held
    int         m_cand;
    int         m_streak;
    logic [4:0] m_out;
    int         m_pulse;

    function automatic void model_reset();
        m_mode = 0; m_cand = 0; m_streak = 0; m_out = 5'b0; m_pulse = 0;
    endfunction

    function automatic void model_scan(input logic [15:0] k);
        int code = 0;
        bit hit  = (k != 16'h0);
        bit same;
        for (int i = 15; i >= 0; i--) if (k[i]) code = layout[i];
        same    = hit && (code == m_cand);
        m_pulse = 0;
        case (m_mode)
            0: if (hit) begin
                m_cand = code; m_streak = 1; m_mode = 1;
                if (m_streak == DB) begin
                    m_out = {1'b1, 4'(m_cand)}; m_mode = 2; m_streak = 0; m_pulse = 1;
                end
            end
            1: if (same) begin
                m_streak++;
                if (m_streak == DB) begin
                    m_out = {1'b1, 4'(m_cand)}; m_mode = 2; m_streak = 0; m_pulse = 1;
                end
            end else begin
                m_streak = 0; m_mode = 0;
            end
            default: if (same) begin
                m_streak = 0;
            end else begin
                m_streak++;
                if (m_streak == DB) begin
                    m_out[4] = 1'b0; m_mode = 0; m_streak = 0;
                end
            end
        endcase
    endfunction

    // ---------------- stimulus: one full scan with a fixed key set ----------------
    logic [4:0] obs_start;
    int         obs_mid_chg;
    int         obs_pulses;
    logic       obs_pulse_end;

    task automatic run_scan(input logic [15:0] k);
        pressed       = k;
        obs_start     = kb_idx;
        obs_mid_chg   = 0;
        obs_pulses    = 0;
        obs_pulse_end = 1'b0;
        for (int i = 1; i <= 4 * SD; i++) begin
            @(negedge clk);
            if (i < 4 * SD && kb_idx !== obs_start) obs_mid_chg++;
`ifdef KB_PRESS_PULSE_EN
            if (kb_press === 1'b1) obs_pulses++;
            if (i == 4 * SD) obs_pulse_end = kb_press;
`endif
        end
        model_scan(k);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] exp_row;
        #12;
        checks++;
        if (row_n !== 4'b1110) begin errors++; $display("FAIL reset_row got %b want 1110", row_n); end
        checks++;
        if (kb_idx !== 5'b0) begin errors++; $display("FAIL reset_idx got %b want 00000", kb_idx); end
`ifdef KB_PRESS_PULSE_EN
        checks++;
        if (kb_press !== 1'b0) begin errors++; $display("FAIL reset_press got %b want 0", kb_press); end
`endif
        @(negedge clk);
        pressed = 16'h0;
        model_reset();
        rst_n = 1'b1;
        for (int k = 1; k <= 4 * SD; k++) begin
            @(negedge clk);
            exp_row = ~(4'b0001 << ((k / SD) % 4));
            checks++;
            if (row_n !== exp_row) begin errors++; $display("FAIL row_rotate cyc%0d got %b want %b", k, row_n, exp_row); end
        end
        model_scan(16'h0);
        // reach held state, start releasing, then reset in the middle of a scan
        for (int s = 0; s < 4; s++) run_scan(16'h0020);
        run_scan(16'h0000);
        pressed = 16'h0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (row_n !== 4'b1110) begin errors++; $display("FAIL midreset_row got %b want 1110", row_n); end
        checks++;
        if (kb_idx !== 5'b0) begin errors++; $display("FAIL midreset_idx got %b want 00000", kb_idx); end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) run_scan(16'h0020);
        checks++;
        if (kb_idx !== 5'b0) begin errors++; $display("FAIL after_reset_partial got %b want 00000", kb_idx); end
        for (int s = 0; s < 4; s++) run_scan(16'h0000);
    endtask

    task automatic test_press_release();
        for (int s = 0; s < 8; s++) begin
            run_scan(s < 4 ? 16'h0020 : 16'h0000);
            checks++;
            if (kb_idx !== m_out) begin errors++; $display("FAIL press5 scan%0d got %b want %b", s, kb_idx, m_out); end
            checks++;
            if (obs_mid_chg != 0) begin errors++; $display("FAIL press5_midscan scan%0d changes %0d want 0", s, obs_mid_chg); end
            if (s == 2) begin
                checks++;
                if (kb_idx !== 5'b1_0101) begin errors++; $display("FAIL press5_commit got %b want 10101", kb_idx); end
            end
            if (s == 6) begin
                checks++;
                if (kb_idx !== 5'b0_0101) begin errors++; $display("FAIL release5 got %b want 00101", kb_idx); end
            end
        end
    endtask

    task automatic test_bounce();
        for (int s = 0; s < 10; s++) begin
            run_scan(s[0] ? 16'h0000 : 16'h4000);
            checks++;
            if (kb_idx[4] !== 1'b0 || kb_idx !== m_out) begin
                errors++; $display("FAIL bounce scan%0d got %b want %b", s, kb_idx, m_out);
            end
        end
        for (int s = 0; s < 4; s++) begin
            run_scan(16'h4000);
            if (s == 2) begin
                checks++;
                if (kb_idx !== 5'b1_1111) begin errors++; $display("FAIL bounce_hold got %b want 11111", kb_idx); end
            end
        end
        for (int s = 0; s < 4; s++) run_scan(16'h0000);
        checks++;
        if (kb_idx !== m_out) begin errors++; $display("FAIL bounce_release got %b want %b", kb_idx, m_out); end
    endtask

    task automatic test_two_keys();
        for (int s = 0; s < 4; s++) run_scan(16'h2008);
        checks++;
        if (kb_idx !== 5'b1_1010) begin errors++; $display("FAIL two_keys got %b want 11010", kb_idx); end
        checks++;
        if (kb_idx !== m_out) begin errors++; $display("FAIL two_keys_model got %b want %b", kb_idx, m_out); end
        for (int s = 0; s < 4; s++) run_scan(16'h0000);
    endtask

    task automatic test_key_change();
        for (int s = 0; s < 3; s++) run_scan(16'h8000);
        checks++;
        if (kb_idx !== 5'b1_1101) begin errors++; $display("FAIL change_D got %b want 11101", kb_idx); end
        for (int s = 0; s < 6; s++) begin
            run_scan(16'h0001);
            checks++;
            if (kb_idx !== m_out) begin errors++; $display("FAIL change scan%0d got %b want %b", s, kb_idx, m_out); end
            if (s == 1 && kb_idx !== 5'b1_1101) begin
                errors++; $display("FAIL change_early_drop got %b want 11101", kb_idx);
            end
            if (s == 2) begin
                checks++;
                if (kb_idx !== 5'b0_1101) begin errors++; $display("FAIL change_drop got %b want 01101", kb_idx); end
            end
            if (s == 4) begin
                checks++;
                if (kb_idx !== 5'b0_1101) begin errors++; $display("FAIL change_early_rise got %b want 01101", kb_idx); end
            end
        end
        checks++;
        if (kb_idx !== 5'b1_0001) begin errors++; $display("FAIL change_rise got %b want 10001", kb_idx); end
        for (int s = 0; s < 4; s++) run_scan(16'h0000);
    endtask

    task automatic test_random();
        logic [15:0] k;
        int          kind;
        int          len;
        for (int seg = 0; seg < 40; seg++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       k = 16'h0;
                3:       k = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: k = 16'h1 << $urandom_range(0, 15);
            endcase
            len = $urandom_range(1, 5);
            for (int s = 0; s < len; s++) begin
                run_scan(k);
                checks++;
                if (kb_idx !== m_out) begin
                    errors++; $display("FAIL random seg%0d keys %h got %b want %b", seg, k, kb_idx, m_out);
                end
                checks++;
                if (obs_mid_chg != 0) begin errors++; $display("FAIL random_midscan seg%0d changes %0d want 0", seg, obs_mid_chg); end
`ifdef KB_PRESS_PULSE_EN
                checks++;
                if (obs_pulses != m_pulse || int'(obs_pulse_end) != m_pulse) begin
                    errors++; $display("FAIL random_pulse seg%0d got %0d end %b want %0d", seg, obs_pulses, obs_pulse_end, m_pulse);
                end
`endif
            end
        end
        for (int s = 0; s < 4; s++) run_scan(16'h0000);
    endtask

`ifdef KB_PRESS_PULSE_EN
    task automatic test_pulse();
        int total = 0;
        for (int s = 0; s < 8; s++) begin
            run_scan(16'h1000);
            total += obs_pulses;
            if (s == 2) begin
                checks++;
                if (obs_pulse_end !== 1'b1 || kb_idx !== 5'b1_1110) begin
                    errors++; $display("FAIL pulse_coincide press %b idx %b want 1 11110", obs_pulse_end, kb_idx);
                end
            end
        end
        checks++;
        if (total != 1) begin errors++; $display("FAIL pulse_count got %0d want 1", total); end
        for (int s = 0; s < 4; s++) run_scan(16'h0000);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_press_release();
        test_bounce();
        test_two_keys();
        test_key_change();
`ifdef KB_PRESS_PULSE_EN
        test_pulse();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/kb_matrix_scanner.md
Name: kb_matrix_scanner

Overview:
Scans a 4x4 matrix keypad and debounces it, then presents the result as the 5-bit keyboard index consumed by the MMIO memory block.
- Bit [4] = key held; bits [3:0] = key code.
- Sits between the board keypad pins and the memory-mapped keyboard registers (enable read at 0xffff_ff34, code read at 0xffff_ff38).
- Producer end of the `kb_idx` interface.

Parameters:
SCAN_DIV, 50000, clock cycles each row is driven before its columns are sampled (≥4).
DEBOUNCE, 4, consecutive full scans needed to commit a press or a release (≥1).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
row_n  output  4  row drive, one-cold; the driven row is 0, the others are 1
col_n  input  4  column sense, active-low (pulled up on board), asynchronous
kb_idx  output  5  [4] = key held, [3:0] = code (0-9 → 0-9, A-D → 10-13, * → 14, # → 15)

Behaviour:
- Reset (async assert, sync release):
  - row_n = 4'b1110, kb_idx = 5'b0_0000.
  - Row/divider/debounce counters = 0; FSM = IDLE.
- Synchroniser: col_n passes through 2 flops before any use.
- Row slot:
  - Divider counts 0..SCAN_DIV-1 while row r is driven.
  - On count SCAN_DIV-1: sample the synchronised columns for row r, advance r (3 wraps to 0) and rotate row_n.
  - Full scan = 4*SCAN_DIV cycles. "Scan end" = the sample cycle of row 3.
- Per-scan result, built during the scan:
  - hit = any column low in any row.
  - code = first low position in row order 0→3, then column order 0→3.
  - Multiple keys down: the first position wins; the others are ignored.
- Keypad layout (row, col 0..3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- FSM; transitions occur only at scan end:
  - IDLE: if hit, cand := code and cnt := 1; if DEBOUNCE==1, commit immediately (→HELD); otherwise →PRESS.
  - PRESS:
    - hit and code==cand: cnt++. When cnt reaches DEBOUNCE: kb_idx := {1, cand}, cnt := 0, →HELD.
    - Otherwise: cnt := 0, →IDLE.
  - HELD:
    - hit and code==cand: cnt := 0.
    - Otherwise: cnt++. When cnt reaches DEBOUNCE: kb_idx[4] := 0, [3:0] keeps the last code, cnt := 0, →IDLE.
    - A different key while held counts as release. The new key is detected only after returning to IDLE.
- kb_idx is registered and changes only in the cycle after scan end.
- Latency:
  - Press: stable press to kb_idx[4]=1 takes ≤ (DEBOUNCE+1) full scans + 3 cycles.
  - Release: symmetric.
- Counters: cnt sized for DEBOUNCE, no wrap. Divider counts up to SCAN_DIV-1 and wraps to 0.
- Reset mid-scan or mid-debounce: all state returns to its reset value immediately. No partial result survives.

Optional Feature:
KB_PRESS_PULSE_EN
- Defined: adds output `kb_press` (1 bit, reset 0). It is high for exactly one clk in the same cycle kb_idx[4] rises (PRESS→HELD). Software can use it as an edge/interrupt source.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE=3, so one scan = 16 cycles.
- Reset: hold rst_n=0 mid-scan, release → row_n=4'b1110, kb_idx=5'b00000; row_n rotates 1110→1101→1011→0111 every 4 cycles.
- Press '5' (col_n[1] low while row_n[1]=0), held steady → kb_idx=5'b1_0101 within 4 scans (≤67 cycles). Release → kb_idx=5'b0_0101 within 4 scans.
- Bounce: press '#' (row3,col2) for 1 scan, release for 1 scan, repeat 5 times → kb_idx[4] stays 0 throughout. Then hold it → kb_idx=5'b1_1111.
- Two keys: hold 'A' (row0,col3) and '0' (row3,col1) together → kb_idx=5'b1_1010 ('A' wins by row order).
- Key change while held: 'D' held (5'b1_1101), switch to '1' → kb_idx[4] drops after 3 scans, then rises with code 0001 after 3 more.
- With KB_PRESS_PULSE_EN: press '*' → kb_press high exactly 1 cycle, coincident with kb_idx becoming 5'b1_1110. No further pulse while held.
